// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider (z = a / b), one quotient bit per cycle,
// round-to-nearest-even, with stb/ack handshakes matching the multiplier.
module fp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    StGetAb,
    StUnpack,
    StSpecial,
    StNormA,
    StNormB,
    StDiv0,
    StDiv1,
    StDiv2,
    StNorm2,
    StRound,
    StPack,
    StPutZ
  } state_e;

  localparam logic signed [9:0] EBias = 10'sd127;
  localparam logic signed [9:0] EMax  = 10'sd127;
  localparam logic signed [9:0] EInf  = 10'sd128;
  localparam logic signed [9:0] EMin  = -10'sd126;
  localparam logic signed [9:0] EZero = -10'sd127;
  localparam logic [31:0]       QNan  = 32'hFFC0_0000;

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d;
  logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d;
  logic               a_s_q, a_s_d, b_s_q, b_s_d;
  logic [23:0]        z_m_q, z_m_d;
  logic signed [9:0]  z_e_q, z_e_d;
  logic               z_s_q, z_s_d;
  logic               guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
  logic [27:0]        quot_q, quot_d;
  logic [23:0]        rem_q, rem_d;
  logic [27:0]        dvd_q, dvd_d;
  logic [4:0]         count_q, count_d;
  logic [31:0]        z_q, z_d;
  logic               ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic               stb_q, stb_d;
  logic [31:0]        out_z_q, out_z_d;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s_xor;
  logic [24:0] trial;

  assign input_a_ack  = ack_a_q;
  assign input_b_ack  = ack_b_q;
  assign output_z_stb = stb_q;
  assign output_z     = out_z_q;

  // Only meaningful in StSpecial, before the hidden bit has been inserted.
  assign a_nan  = (a_e_q == EInf) && (a_m_q[22:0] != 23'd0);
  assign b_nan  = (b_e_q == EInf) && (b_m_q[22:0] != 23'd0);
  assign a_inf  = (a_e_q == EInf) && (a_m_q[22:0] == 23'd0);
  assign b_inf  = (b_e_q == EInf) && (b_m_q[22:0] == 23'd0);
  assign a_zero = (a_e_q == EZero) && (a_m_q[22:0] == 23'd0);
  assign b_zero = (b_e_q == EZero) && (b_m_q[22:0] == 23'd0);
  assign s_xor  = a_s_q ^ b_s_q;

  assign trial = {rem_q, dvd_q[27]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a_m_d    = a_m_q;
    b_m_d    = b_m_q;
    a_e_d    = a_e_q;
    b_e_d    = b_e_q;
    a_s_d    = a_s_q;
    b_s_d    = b_s_q;
    z_m_d    = z_m_q;
    z_e_d    = z_e_q;
    z_s_d    = z_s_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    count_d  = count_q;
    z_d      = z_q;
    ack_a_d  = ack_a_q;
    ack_b_d  = ack_b_q;
    stb_d    = stb_q;
    out_z_d  = out_z_q;

    unique case (state_q)
      StGetAb: begin
        ack_a_d = 1'b1;
        ack_b_d = 1'b1;
        if (ack_a_q && ack_b_q && input_a_stb && input_b_stb) begin
          a_d     = input_a;
          b_d     = input_b;
          ack_a_d = 1'b0;
          ack_b_d = 1'b0;
          state_d = StUnpack;
        end
      end

      StUnpack: begin
        a_m_d   = {1'b0, a_q[22:0]};
        b_m_d   = {1'b0, b_q[22:0]};
        a_e_d   = $signed({2'b00, a_q[30:23]}) - EBias;
        b_e_d   = $signed({2'b00, b_q[30:23]}) - EBias;
        a_s_d   = a_q[31];
        b_s_d   = b_q[31];
        state_d = StSpecial;
      end

      StSpecial: begin
        state_d = StPutZ;
        if (a_nan || b_nan) begin
          z_d = QNan;
        end else if (a_inf && b_inf) begin
          z_d = QNan;
        end else if (a_inf) begin
          z_d = {s_xor, 8'hFF, 23'd0};
        end else if (b_inf) begin
          z_d = {s_xor, 31'd0};
        end else if (a_zero && b_zero) begin
          z_d = QNan;
        end else if (b_zero) begin
          z_d = {s_xor, 8'hFF, 23'd0};
        end else if (a_zero) begin
          z_d = {s_xor, 31'd0};
        end else begin
          if (a_e_q == EZero) a_e_d = EMin;
          else                a_m_d[23] = 1'b1;
          if (b_e_q == EZero) b_e_d = EMin;
          else                b_m_d[23] = 1'b1;
          state_d = StNormA;
        end
      end

      StNormA: begin
        if (a_m_q[23]) begin
          state_d = StNormB;
        end else begin
          a_m_d = {a_m_q[22:0], 1'b0};
          a_e_d = a_e_q - 10'sd1;
        end
      end

      StNormB: begin
        if (b_m_q[23]) begin
          state_d = StDiv0;
        end else begin
          b_m_d = {b_m_q[22:0], 1'b0};
          b_e_d = b_e_q - 10'sd1;
        end
      end

      StDiv0: begin
        z_s_d   = s_xor;
        z_e_d   = a_e_q - b_e_q;
        quot_d  = 28'd0;
        // Dividend is a_m<<27; its top 23 bits are below the divisor and yield
        // only zero quotient bits, so they start out as the partial remainder.
        rem_d   = {1'b0, a_m_q[23:1]};
        dvd_d   = {a_m_q[0], 27'd0};
        count_d = 5'd0;
        state_d = StDiv1;
      end

      StDiv1: begin
        if (trial >= {1'b0, b_m_q}) begin
          rem_d  = 24'(trial - {1'b0, b_m_q});
          quot_d = {quot_q[26:0], 1'b1};
        end else begin
          rem_d  = trial[23:0];
          quot_d = {quot_q[26:0], 1'b0};
        end
        dvd_d   = {dvd_q[26:0], 1'b0};
        count_d = count_q + 5'd1;
        if (count_q == 5'd27) state_d = StDiv2;
      end

      StDiv2: begin
        if (quot_q[27]) begin
          z_m_d    = quot_q[27:4];
          guard_d  = quot_q[3];
          round_d  = quot_q[2];
          sticky_d = (|quot_q[1:0]) | (rem_q != 24'd0);
        end else begin
          z_m_d    = quot_q[26:3];
          guard_d  = quot_q[2];
          round_d  = quot_q[1];
          sticky_d = quot_q[0] | (rem_q != 24'd0);
          z_e_d    = z_e_q - 10'sd1;
        end
        state_d = StNorm2;
      end

      StNorm2: begin
        if (z_e_q < EMin) begin
          z_e_d    = z_e_q + 10'sd1;
          z_m_d    = {1'b0, z_m_q[23:1]};
          guard_d  = z_m_q[0];
          round_d  = guard_q;
          sticky_d = sticky_q | round_q;
        end else begin
          state_d = StRound;
        end
      end

      StRound: begin
        if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == 24'hFF_FFFF) z_e_d = z_e_q + 10'sd1;
        end
        state_d = StPack;
      end

      StPack: begin
        z_d = {z_s_q, z_e_q[7:0] + 8'd127, z_m_q[22:0]};
        if ((z_e_q == EMin) && !z_m_q[23]) z_d[30:23] = 8'd0;
        if (z_e_q > EMax) z_d = {z_s_q, 8'hFF, 23'd0};
        state_d = StPutZ;
      end

      StPutZ: begin
        stb_d   = 1'b1;
        out_z_d = z_q;
        if (stb_q && output_z_ack) begin
          stb_d   = 1'b0;
          state_d = StGetAb;
        end
      end

      default: state_d = StGetAb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StGetAb;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      a_m_q    <= 24'd0;
      b_m_q    <= 24'd0;
      a_e_q    <= 10'sd0;
      b_e_q    <= 10'sd0;
      a_s_q    <= 1'b0;
      b_s_q    <= 1'b0;
      z_m_q    <= 24'd0;
      z_e_q    <= 10'sd0;
      z_s_q    <= 1'b0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      quot_q   <= 28'd0;
      rem_q    <= 24'd0;
      dvd_q    <= 28'd0;
      count_q  <= 5'd0;
      z_q      <= 32'd0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      stb_q    <= 1'b0;
      out_z_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_m_q    <= a_m_d;
      b_m_q    <= b_m_d;
      a_e_q    <= a_e_d;
      b_e_q    <= b_e_d;
      a_s_q    <= a_s_d;
      b_s_q    <= b_s_d;
      z_m_q    <= z_m_d;
      z_e_q    <= z_e_d;
      z_s_q    <= z_s_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      count_q  <= count_d;
      z_q      <= z_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      stb_q    <= stb_d;
      out_z_q  <= out_z_d;
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: results, latencies, handshakes, reset.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] input_b = '0;
  logic        input_b_stb = 1'b0;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  fp_divider dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present operands and return once the capture edge has passed.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok = 1'b0;
    input_a = a;
    input_b = b;
    input_a_stb = 1'b1;
    input_b_stb = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (input_a_ack && input_b_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
  endtask

  // Count edges after capture until stb is seen; track whether acks ever rose.
  task automatic wait_result(output int lat, output bit acks_high);
    lat = -1;
    acks_high = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (input_a_ack || input_b_ack) acks_high = 1'b1;
      if (output_z_stb) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic accept();
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_z, input int exp_lat);
    bit ok;
    int lat;
    bit acks_high;
    start_op(a, b, ok);
    check({tag, "_capture"}, 32'(ok), 32'd1);
    if (!ok) return;
    wait_result(lat, acks_high);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_acks_low"}, 32'(acks_high), 32'd0);
    check({tag, "_z"}, output_z, exp_z);
    if (lat > 0) accept();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;
    bit acks_high;
    bit stable;
    bit saw_stb;
    logic [31:0] z0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack_a", 32'(input_a_ack), 32'd0);
    check("rst_ack_b", 32'(input_b_ack), 32'd0);
    check("rst_stb", 32'(output_z_stb), 32'd0);
    check("rst_z", output_z, 32'd0);
    rst = 1'b0;

    do_div("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 38);
    check("stb_dropped", 32'(output_z_stb), 32'd0);
    do_div("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 38);
    do_div("neg_third", 32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 38);

    do_div("div_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3);
    do_div("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'hFFC0_0000, 3);
    do_div("inf_inf", 32'h7F80_0000, 32'h7F80_0000, 32'hFFC0_0000, 3);
    do_div("by_neg_inf", 32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 3);
    do_div("nan_a", 32'h7FC0_0001, 32'h3F80_0000, 32'hFFC0_0000, 3);

    do_div("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 38);
    do_div("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0040_0000, 39);
    do_div("denorm_in", 32'h0040_0000, 32'h0040_0000, 32'h3F80_0000, 40);

    // Backpressure: result must hold while ack stays low.
    start_op(32'h40C0_0000, 32'h4000_0000, ok);
    check("bp_capture", 32'(ok), 32'd1);
    wait_result(lat, acks_high);
    check("bp_lat", 32'(lat), 32'd38);
    z0 = output_z;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!output_z_stb || output_z !== z0) stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_z", output_z, 32'h4040_0000);
    accept();

    // A lone dividend strobe must never capture.
    input_a = 32'h40C0_0000;
    input_a_stb = 1'b1;
    input_b_stb = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("lone_stb_ack_a", 32'(input_a_ack), 32'd1);
    check("lone_stb_ack_b", 32'(input_b_ack), 32'd1);
    input_a_stb = 1'b0;

    // Reset in the middle of the quotient loop abandons the operation.
    start_op(32'h40C0_0000, 32'h4000_0000, ok);
    check("mid_rst_capture", 32'(ok), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_ack_a", 32'(input_a_ack), 32'd0);
    check("mid_rst_ack_b", 32'(input_b_ack), 32'd0);
    check("mid_rst_stb", 32'(output_z_stb), 32'd0);
    saw_stb = 1'b0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (output_z_stb) saw_stb = 1'b1;
    end
    check("mid_rst_no_result", 32'(saw_stb), 32'd0);
    do_div("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 38);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
# fp_divider

IEEE-754 single-precision floating-point divider (z = a / b) for the GMM datapath, used alongside the existing floating-point multiplier for weight normalisation and variance-ratio terms. It uses the same stb/ack operand and result handshake, so it can be swapped into any multiplier slot. Division is iterative, one quotient bit per cycle, with round-to-nearest-even and full handling of denormals, zeros, infinities and NaN.

## Interface
- No parameters.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- input_a  input  32  dividend, IEEE-754 single.
- input_a_stb  input  1  dividend valid.
- input_a_ack  output  1  dividend accepted/ready.
- input_b  input  32  divisor, IEEE-754 single.
- input_b_stb  input  1  divisor valid.
- input_b_ack  output  1  divisor accepted/ready.
- output_z  output  32  quotient, registered.
- output_z_stb  output  1  quotient valid.
- output_z_ack  input  1  consumer accepts quotient.

## Operation
- Reset, with priority over all states: state=get_ab, input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0. Reset during any state, including mid-division, abandons the operation; no result is emitted.
- get_ab: drives both acks to 1. Capture occurs on an edge where both acks are already 1 and both stbs are 1. On capture, latch a and b, drop both acks to 0, go to unpack. One stb alone never captures.
- unpack: split fields. Mantissas take the 23 fraction bits. Exponents are 10-bit signed, computed as field − 127.
- special_cases, checked in this order (sign s = a_s^b_s):
  - a or b is NaN → 0xFFC00000.
  - a inf and b inf → 0xFFC00000.
  - a inf → {s, 0xFF, 0}.
  - b inf → {s, 0, 0}, i.e. signed zero.
  - a zero and b zero → 0xFFC00000.
  - b zero → {s, 0xFF, 0}, i.e. signed inf.
  - a zero → {s, 0, 0}.
  - All of these go to put_z.
  - Otherwise: a denormal input gets exponent −126; a normal input gets hidden bit 23 set. Go to normalise_a.
- normalise_a, then normalise_b: shift mantissa left and decrement exponent, one bit per cycle, until bit 23 is set.
- divide_0:
  - z_s = a_s^b_s; z_e = a_e − b_e.
  - Dividend = a_m<<27; divisor = b_m; quotient Q (28 b) = 0; remainder R = 0; count = 0.
- divide_1: restoring division, one bit per cycle, MSB first, for 28 cycles. Each cycle: R = (R<<1) | next dividend bit; if R ≥ divisor then subtract and shift in a 1, else shift in a 0.
- divide_2: Q lies in [2^26, 2^28).
  - If Q[27]=1: z_m = Q[27:4], guard = Q[3], round_bit = Q[2], sticky = |Q[1:0] | (R≠0).
  - If Q[27]=0: z_m = Q[26:3], guard = Q[2], round_bit = Q[1], sticky = Q[0] | (R≠0), and z_e decrements by 1.
- normalise_2: while signed z_e < −126, per cycle: z_e += 1, z_m >>= 1, guard ← z_m[0], round_bit ← guard, sticky |= round_bit.
- round: if guard & (round_bit | sticky | z_m[0]), then z_m += 1; if z_m was 0xFFFFFF, z_e += 1.
- pack:
  - Default: z = {z_s, z_e[7:0]+127, z_m[22:0]}.
  - If z_e == −126 and z_m[23] == 0: exponent field = 0 (denormal result).
  - If signed z_e > 127: z = {z_s, 0xFF, 0}.
- put_z: output_z_stb = 1 and output_z = z. When output_z_stb and output_z_ack are both 1 on an edge, drop stb and return to get_ab.

## Timing
- Capture on edge N. For normal operands with normal result, output_z_stb rises after edge N+38 (unpack 1, special 1, norm_a 1, norm_b 1, div_0 1, div_1 28, div_2 1, norm_2 1, round 1, pack 1, put_z 1).
- Each denormal input adds one cycle per leading zero. Each underflow right-shift adds one cycle.
- Special-case results: stb rises after edge N+3.
- output_z holds stable while stb=1 and ack=0, for any number of cycles.
- The acks are 0 from the capture edge until the block re-enters get_ab. The earliest next capture is 2 edges after the result handshake.
- Throughput: one division per ≥41 cycles.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → 0x40400000; stb rises exactly 38 edges after capture; acks low throughout.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB, which checks the round-up; 0xBF800000 / 0x40400000 → 0xBEAAAAAB.
- Special cases:
  - 0x3F800000/0x00000000 → 0x7F800000
  - 0x00000000/0x00000000 → 0xFFC00000
  - 0x7F800000/0x7F800000 → 0xFFC00000
  - 0x3F800000/0xFF800000 → 0x80000000
  - 0x7FC00001/any → 0xFFC00000
  - each with stb at N+3.
- Range limits:
  - Overflow: 0x7F000000 / 0x3E800000 → 0x7F800000.
  - Underflow/denormal: 0x00800000 / 0x40000000 → 0x00400000.
  - Denormal input: 0x00400000 / 0x00400000 → 0x3F800000.
- Backpressure: hold output_z_ack low 10 cycles after stb → stb and output_z stable. Hold input_b_stb low with input_a_stb high → no capture.
- Assert rst for 1 cycle during divide_1 → the next cycle has acks=0 and stb=0, no output. The next operand pair (6/2) produces 0x40400000 normally.
